mem_bus_arbiter: RTL

Shares the single synchronous main RAM between N requesters: CPU load/store path, DMA engine and video fetch.
- Arbitration is round-robin, with an optional bounded lock that lets one owner run back-to-back accesses.
- Sits between the requesters and the RAM macro; the CPU control unit's memory strobes feed requester 0.
- RAM is synchronous: read data is valid one cycle after mem_en.

---
 rtl/mem_bus_arbiter_pkg.sv | 30 +++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter_rr_pick.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and defaults for the main-RAM bus arbiter:
//             FSM state encoding, default bus geometry and an index-width
//             helper used to size requester pointers.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_N_REQ    = 3;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Width needed to index n items; a single item still gets one bit so the
  // pointer and owner registers never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter_if
//  Purpose  : Bundle of requester-side and RAM-side signals of the arbiter.
//  Ports    : master - requesters + RAM model (drive req/lock/we/addr/wdata
//                      and mem_rdata, observe gnt/ack/rdata and mem_*)
//             slave  - the arbiter itself (mirror image)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    output req, lock, we, addr, wdata, mem_rdata,
    input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, lock, we, addr, wdata, mem_rdata,
    output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Finds the first set request
//             at or after the pointer, wrapping past the top index.
//  Ports    : i_req   - request vector
//             i_ptr   - starting index (highest priority)
//             o_valid - any request set
//             o_index - chosen requester
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  int w_j;

  // Scan offsets from the farthest back to the nearest; the last hit
  // written is the one closest to the pointer, i.e. the winner.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_valid = 1'b1;
        o_index = IW'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Round-robin arbiter sharing one synchronous RAM between
//             N_REQ requesters (0 = CPU), with a bounded burst lock.
//             Each access is ACCESS (strobe RAM) then RESP (ack + data).
//  Ports    : clk - system clock
//             r   - synchronous active-high reset
//             bus - requester / RAM bundle (slave side)
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               r,
  mem_bus_arbiter_if.slave   bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] C_LAST_REQ  = IW'(N_REQ - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [IW-1:0]     r_owner, w_owner_nxt;
  logic [IW-1:0]     r_ptr,   w_ptr_nxt;
  logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
  logic              r_wr;

  logic              w_pick_valid;
  logic [IW-1:0]     w_pick_idx;
  logic [N_REQ-1:0]  w_owner_oh;

  logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
  logic [DATA_W-1:0] w_wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (r) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_wr       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      // Remember the direction of the access in flight so RESP can gate
      // rdata even if the requester has already moved on.
      if (r_state == ACCESS) r_wr <= bus.we[r_owner];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: w_state_nxt = RESP;
      RESP: begin
        // hold_cnt counts extra accesses beyond the first in this tenure.
        if (bus.lock[r_owner] && bus.req[r_owner] &&
            (r_hold_cnt < C_HOLD_LAST)) begin
          w_hold_nxt  = r_hold_cnt + HW'(1);
          w_state_nxt = ACCESS;
        end else begin
          w_hold_nxt  = '0;
          w_ptr_nxt   = (r_owner == C_LAST_REQ) ? '0 : r_owner + IW'(1);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_owner_oh = N_REQ'(1) << r_owner;

  // Output decode
  always_comb begin
    bus.gnt       = '0;
    bus.ack       = '0;
    bus.rdata     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      ACCESS: begin
        bus.gnt       = w_owner_oh;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.we[r_owner];
        bus.mem_addr  = w_addr_arr[r_owner];
        bus.mem_wdata = w_wdata_arr[r_owner];
      end
      RESP: begin
        bus.gnt = w_owner_oh;
        bus.ack = w_owner_oh;
        if (!r_wr) bus.rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
